// File: rtl/serial_word_tx_pkg.sv
// Shared types for the serial word transmitter: FSM state encoding and default word width.
package serial_tx_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

endpackage

// File: rtl/serial_word_tx_if.sv
// Producer-side handshake plus serial output of the word transmitter.
// master = word producer / line observer, slave = transmitter.
interface serial_word_tx_if
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic [WIDTH-1:0] din;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output din, load_valid,
      input  load_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  din, load_valid,
      output load_ready, sout, sout_valid, busy, done
   );

endinterface

// File: rtl/serial_word_tx_piso_shift_reg.sv
// Parallel-in serial-out shift register: load wins over shift, shifts left with zero fill.
module piso_shift_reg
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);

   logic [WIDTH-1:0] shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         shreg <= '0;
      else if (load)
         shreg <= d;
      else if (shift)
         shreg <= {shreg[WIDTH-2:0], 1'b0};
   end

   assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_word_tx.sv
// Word transmitter: valid/ready word intake, MSB-first serial output with strobe and done pulse.
// Optional even-parity trailer bit when PARITY_EN is defined.
module serial_word_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   serial_word_tx_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            last_data;
   logic            last_bit;
   logic            accept;
   logic            msb;

   assign last_data = (state == SHIFT) && (cnt == '0);

`ifdef PARITY_EN
   logic par;
   assign last_bit = (state == PARITY);
`else
   assign last_bit = last_data;
`endif

   // Ready on the last-bit cycle so the next word follows with no gap.
   assign bus.load_ready = (state == IDLE) || last_bit;
   assign accept         = bus.load_valid && bus.load_ready;

   piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (state == SHIFT),
      .d     (bus.din),
      .msb   (msb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
`ifdef PARITY_EN
         par   <= 1'b0;
`endif
      end else if (accept) begin
         state <= SHIFT;
         cnt   <= CW'(WIDTH - 1);
`ifdef PARITY_EN
         par   <= ^bus.din;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (cnt == '0)
`ifdef PARITY_EN
                  state <= PARITY;
`else
                  state <= IDLE;
`endif
               else
                  cnt <= cnt - 1'b1;
            end
`ifdef PARITY_EN
            PARITY:  state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PARITY_EN
   assign bus.sout = ((state == SHIFT) && msb) || ((state == PARITY) && par);
`else
   assign bus.sout = (state == SHIFT) && msb;
`endif

   assign bus.sout_valid = (state != IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.done       = last_bit;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: constant vector table, hand sequences, and a randomized run
// against a bit-queue model of the serial line.
module tb_serial_word_tx;

   localparam int W = 4;
`ifdef PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   serial_word_tx_if #(.WIDTH(W)) bus ();

   serial_word_tx #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] bits;   // expected line bits, first-sent at the top
      logic         par;
   } vec_t;

   vec_t tbl [6];
   bit   q [$];            // expected line contents, front = bit on sout now

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [FL-1:0] frame_of(input logic [W-1:0] w);
`ifdef PARITY_EN
      return {w, ^w};
`else
      return w;
`endif
   endfunction

   task automatic idle_check(input string nm);
      @(negedge clk);
      chk({nm, "_valid"}, bus.sout_valid, 0);
      chk({nm, "_busy"},  bus.busy, 0);
      chk({nm, "_sout"},  bus.sout, 0);
      chk({nm, "_done"},  bus.done, 0);
      chk({nm, "_ready"}, bus.load_ready, 1);
      @(posedge clk); #1;
   endtask

   // Entered and left at posedge+1 with the transmitter idle.
   task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] bits, input logic par);
      logic [W-1:0] rx;
      logic         e;
      rx = '0;
      bus.din = w;
      bus.load_valid = 1'b1;
      @(negedge clk);
      chk("ready_idle", bus.load_ready, 1);
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      bus.din = W'($urandom);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         e = (i < W) ? bits[W-1-i] : par;
         chk("word_sout",  bus.sout, 8'(e));
         chk("word_valid", bus.sout_valid, 1);
         chk("word_done",  bus.done, 8'(i == FL - 1));
         if (i < W) rx = {rx[W-2:0], bus.sout};
         @(posedge clk); #1;
      end
      chk("loopback", rx, w);
      idle_check("after_word");
   endtask

   // Second word presented while the first is in flight, load_valid held.
   task automatic b2b(input logic [W-1:0] w1, input logic [W-1:0] w2);
      logic [FL-1:0] f1, f2;
      logic          e;
      f1 = frame_of(w1);
      f2 = frame_of(w2);
      bus.din = w1;
      bus.load_valid = 1'b1;
      @(posedge clk); #1;
      bus.din = w2;
      for (int i = 0; i < 2 * FL; i++) begin
         @(negedge clk);
         e = (i < FL) ? f1[FL-1-i] : f2[2*FL-1-i];
         chk("b2b_sout",  bus.sout, 8'(e));
         chk("b2b_valid", bus.sout_valid, 1);
         chk("b2b_done",  bus.done, 8'(i == FL - 1 || i == 2 * FL - 1));
         chk("b2b_ready", bus.load_ready, 8'(i == FL - 1 || i == 2 * FL - 1));
         @(posedge clk); #1;
         if (i == FL - 1) bus.load_valid = 1'b0;
      end
      idle_check("after_b2b");
   endtask

   logic acc;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{word: 4'b1011, bits: 4'b1011, par: 1'b1};
      tbl[1] = '{word: 4'b0110, bits: 4'b0110, par: 1'b0};
      tbl[2] = '{word: 4'b0000, bits: 4'b0000, par: 1'b0};
      tbl[3] = '{word: 4'b1111, bits: 4'b1111, par: 1'b0};
      tbl[4] = '{word: 4'b1000, bits: 4'b1000, par: 1'b1};
      tbl[5] = '{word: 4'b0111, bits: 4'b0111, par: 1'b1};

      rst = 1'b1;
      bus.din = '0;
      bus.load_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sout",  bus.sout, 0);
      chk("rst_valid", bus.sout_valid, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_done",  bus.done, 0);
      chk("rst_ready", bus.load_ready, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[k]) send_word(tbl[k].word, tbl[k].bits, tbl[k].par);

      b2b(4'b1011, 4'b0110);
      b2b(4'b1011, 4'b0001);

      // Async reset in the middle of 4'b1100, right after its second bit.
      bus.din = 4'b1100;
      bus.load_valid = 1'b1;
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      @(negedge clk);
      chk("mid_bit0", bus.sout, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_bit1", bus.sout, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", bus.sout_valid, 0);
      chk("mid_rst_sout",  bus.sout, 0);
      chk("mid_rst_busy",  bus.busy, 0);
      chk("mid_rst_done",  bus.done, 0);
      chk("mid_rst_ready", bus.load_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_check("post_rst");
      send_word(4'b0011, 4'b0011, 1'b0);

      // Randomized traffic against the line-queue model.
      q.delete();
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.din = W'($urandom);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         chk("rnd_valid", bus.sout_valid, 8'(q.size() > 0));
         chk("rnd_busy",  bus.busy, 8'(q.size() > 0));
         chk("rnd_sout",  bus.sout, 8'((q.size() > 0) ? q[0] : 1'b0));
         chk("rnd_done",  bus.done, 8'(q.size() == 1));
         chk("rnd_ready", bus.load_ready, 8'(q.size() <= 1));
         acc = bus.load_valid && (q.size() <= 1);
         @(posedge clk); #1;
         if (q.size() > 0) void'(q.pop_front());
         if (acc) begin
            for (int b = W - 1; b >= 0; b--) q.push_back(bus.din[b]);
`ifdef PARITY_EN
            q.push_back(^bus.din);
`endif
         end
         if (acc || !bus.load_valid) begin
            bus.load_valid = ($urandom_range(0, 3) != 0);
            bus.din = W'($urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
